// File: rtl/bram_ctrl_pkg.sv
// Shared constants and types for the BRAM-backed streaming FIFO.
// Output-stage state encoding doubles as its word count.
package bram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } out_state_e;

  function automatic int lvl_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides of the FIFO.
// The master drives valid/data, the slave drives ready.
interface bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/bram_out_skid.sv
// Two-entry output stage absorbing the BRAM read latency.
// Entry d0 is always the head; d1 holds the second word in TWO.
module bram_out_skid
  import bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            cnt,
  output logic                  pop
);

  localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
  localparam logic [1:0] ST_ONE   = 2'(ONE);
  localparam logic [1:0] ST_TWO   = 2'(TWO);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;

  assign valid = (state != ST_EMPTY);
  assign pop   = valid && ready;
  assign data  = d0;
  assign cnt   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      d0    <= '0;
      d1    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (cap) begin
            d0    <= cap_data;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (cap && pop) begin
            d0 <= cap_data;
          end else if (cap) begin
            d1    <= cap_data;
            state <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // capture without pop cannot occur here
          if (pop) begin
            d0 <= d1;
            if (cap) d1 <= cap_data;
            else state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller driving a true dual-port BRAM.
// Optional BRAM_FIFO_STATS_EN adds hwm and ovf_cnt outputs.
module bram_fifo_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_fifo_ctrl_if.slave       s,
  bram_fifo_ctrl_if.master      m,
  output logic [lvl_w(ADDR_WIDTH)-1:0] level,
  output logic                  bram_en0,
  output logic                  bram_we0,
  output logic [ADDR_WIDTH-1:0] bram_addr0,
  output logic [DATA_WIDTH-1:0] bram_d0,
  output logic                  bram_en1,
  output logic                  bram_we1,
  output logic [ADDR_WIDTH-1:0] bram_addr1,
  input  logic [DATA_WIDTH-1:0] bram_q1
`ifdef BRAM_FIFO_STATS_EN
  ,
  output logic [lvl_w(ADDR_WIDTH)-1:0] hwm,
  output logic [15:0]           ovf_cnt
`endif
);

  localparam int LW = lvl_w(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  rd_pend;
  logic [1:0]            out_cnt;
  logic [2:0]            occ;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  sk_valid;
  logic [DATA_WIDTH-1:0] sk_data;

  assign s.ready = !rst && (mem_cnt != DEPTH);
  assign push    = s.valid && s.ready;

  // words already owed to the output stage after this cycle's pop
  assign occ   = {1'b0, out_cnt} + {2'b0, rd_pend}
               - {2'b0, pop};
  assign issue = !rst && (mem_cnt != '0) && (occ < 3'd2);

  assign bram_en0   = push;
  assign bram_we0   = push;
  assign bram_addr0 = rst ? '0 : wr_ptr;
  assign bram_d0    = rst ? '0 : s.data;
  assign bram_en1   = issue;
  assign bram_we1   = 1'b0;
  assign bram_addr1 = rst ? '0 : rd_ptr;

  assign level = LW'(mem_cnt) + LW'(rd_pend) + LW'(out_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr  <= rd_ptr + ADDR_WIDTH'(issue);
      mem_cnt <= mem_cnt + (ADDR_WIDTH+1)'(push)
               - (ADDR_WIDTH+1)'(issue);
      rd_pend <= issue;
    end
  end

  bram_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .cap      (rd_pend),
    .cap_data (bram_q1),
    .ready    (m.ready),
    .valid    (sk_valid),
    .data     (sk_data),
    .cnt      (out_cnt),
    .pop      (pop)
  );

  assign m.valid = sk_valid;
  assign m.data  = sk_data;

`ifdef BRAM_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm     <= '0;
      ovf_cnt <= '0;
    end else begin
      if (level > hwm) hwm <= level;
      if (s.valid && !s.ready && ovf_cnt != 16'hffff)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a small BRAM model.
// Stats checks are built when BRAM_FIFO_STATS_EN is defined.
module tb_bram_fifo_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) sif ();
  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) mif ();

  logic [AW+1:0] level;
  logic          en0, we0, en1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] d0, q1;
`ifdef BRAM_FIFO_STATS_EN
  logic [AW+1:0] hwm;
  logic [15:0]   ovf_cnt;
`endif

  bram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (sif),
    .m          (mif),
    .level      (level),
    .bram_en0   (en0),
    .bram_we0   (we0),
    .bram_addr0 (addr0),
    .bram_d0    (d0),
    .bram_en1   (en1),
    .bram_we1   (we1),
    .bram_addr1 (addr1),
    .bram_q1    (q1)
`ifdef BRAM_FIFO_STATS_EN
    ,
    .hwm        (hwm),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (en0 && we0) mem[addr0] <= d0;
    if (en1) q1 <= mem[addr1];
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [$];

  logic          sn_sready, sn_mvalid, sn_en0, sn_we0;
  logic          sn_en1, sn_we1, sn_pop;
  logic [AW-1:0] sn_addr0, sn_addr1;
  logic [DW-1:0] sn_d0, sn_mdata;
  logic [AW+1:0] sn_level;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sn_sready = sif.ready;
    sn_mvalid = mif.valid;
    sn_mdata  = mif.data;
    sn_level  = level;
    sn_en0    = en0;
    sn_we0    = we0;
    sn_addr0  = addr0;
    sn_d0     = d0;
    sn_en1    = en1;
    sn_we1    = we1;
    sn_addr1  = addr1;
    sn_pop    = mif.valid && mif.ready;
    if (!rst) begin
      chk("level", 32'(level), 32'(q.size()));
      if (mif.valid) begin
        chk("nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("head", 32'(mif.data), 32'(q[0]));
      end
      if (level < DEPTH) chk("s_ready_free", 32'(sif.ready), 1);
      if (sn_pop && q.size() != 0) void'(q.pop_front());
      if (sif.valid && sif.ready) q.push_back(sif.data);
    end else begin
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int nacc;
  int nout;

  initial begin
    rst       = 1'b1;
    sif.valid = 1'b0;
    sif.data  = '0;
    mif.ready = 1'b0;
    cyc();
    cyc();
    chk("rst_s_ready", 32'(sn_sready), 0);
    chk("rst_m_valid", 32'(sn_mvalid), 0);
    chk("rst_m_data",  32'(sn_mdata), 0);
    chk("rst_level",   32'(sn_level), 0);
    chk("rst_bram", 32'({sn_en0, sn_we0, sn_en1, sn_we1,
                          sn_addr0, sn_addr1, sn_d0}), 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_s_ready", 32'(sn_sready), 1);

    // single word through an empty FIFO
    sif.valid = 1'b1;
    sif.data  = 16'hA5A5;
    cyc();
    chk("T_en0",   32'(sn_en0), 1);
    chk("T_we0",   32'(sn_we0), 1);
    chk("T_addr0", 32'(sn_addr0), 0);
    chk("T_d0",    32'(sn_d0), 32'h0000A5A5);
    sif.valid = 1'b0;
    cyc();
    chk("T1_en1",   32'(sn_en1), 1);
    chk("T1_addr1", 32'(sn_addr1), 0);
    chk("T1_level", 32'(sn_level), 1);
    cyc();
    chk("T2_m_valid", 32'(sn_mvalid), 0);
    cyc();
    chk("T3_m_valid", 32'(sn_mvalid), 1);
    chk("T3_m_data",  32'(sn_mdata), 32'h0000A5A5);
    chk("T3_level",   32'(sn_level), 1);
    mif.ready = 1'b1;
    cyc();
    mif.ready = 1'b0;
    cyc();

    // continuous stream with consumer always ready
    nout = 0;
    for (int i = 0; i < 106; i++) begin
      sif.valid = (i < 100);
      sif.data  = 16'(i);
      mif.ready = 1'b1;
      cyc();
      if (i < 100) chk("stream_s_ready", 32'(sn_sready), 1);
      chk("stream_m_valid", 32'(sn_mvalid),
          32'(i >= 3 && i < 103));
      if (sn_pop) nout++;
    end
    chk("stream_count", 32'(nout), 100);

    // fill to full with consumer stalled
    sif.valid = 1'b0;
    mif.ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 14; i++) begin
      sif.valid = 1'b1;
      sif.data  = 16'(16'h100 + nacc);
      cyc();
      chk("full_s_ready", 32'(sn_sready), 32'(nacc < 10));
      if (sn_sready) nacc++;
    end
    sif.valid = 1'b0;
    chk("full_accepted", 32'(nacc), 10);
    cyc();
    chk("full_level", 32'(sn_level), 10);
    mif.ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (sn_pop) nout++;
    end
    chk("drain_count", 32'(nout), 10);
    chk("drain_level", 32'(sn_level), 0);

    // random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      sif.valid = 1'($urandom_range(1));
      sif.data  = 16'($urandom);
      mif.ready = 1'($urandom_range(1));
      cyc();
    end
    sif.valid = 1'b0;
    mif.ready = 1'b1;
    for (int i = 0; i < 14; i++) cyc();

    // reset with words in flight
    mif.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sif.valid = 1'b1;
      sif.data  = 16'(16'h700 + i);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst       = 1'b0;
    sif.valid = 1'b0;
    cyc();
    chk("rst2_m_valid", 32'(sn_mvalid), 0);
    chk("rst2_level",   32'(sn_level), 0);
    chk("rst2_s_ready", 32'(sn_sready), 1);
    sif.valid = 1'b1;
    sif.data  = 16'h1234;
    cyc();
    sif.valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    mif.ready = 1'b1;
    cyc();
    chk("rst2_first_valid", 32'(sn_mvalid), 1);
    chk("rst2_first_data",  32'(sn_mdata), 32'h1234);
    mif.ready = 1'b0;
    cyc();

`ifdef BRAM_FIFO_STATS_EN
    // stall the writer against a full FIFO
    sif.valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sif.data = 16'(16'h900 + i);
      cyc();
      if (!sn_sready) break;
    end
    chk("stats_full", 32'(sn_sready), 0);
    for (int i = 0; i < 4; i++) cyc();
    sif.valid = 1'b0;
    cyc();
    chk("stats_ovf", 32'(ovf_cnt), 5);
    chk("stats_hwm", 32'(hwm), DEPTH + 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
